// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared state encodings and default frame geometry for frame_xmtr/rcvr
`timescale 1ns/1ps

package frame_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HDR     = 2'd1,
        BODY    = 2'd2
    } frame_state_e;

    localparam int                             DEFAULT_HEADER_SIZE  = 8;
    localparam logic [DEFAULT_HEADER_SIZE-1:0] DEFAULT_HEADER_VALUE = 8'hA5;
    localparam int                             DEFAULT_BODY_SIZE    = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_piso.sv
// rtl/frame_piso.sv - parallel-load, MSB-first shift register feeding SDATA
`timescale 1ns/1ps

module frame_piso
    import frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_HEADER_SIZE + DEFAULT_BODY_SIZE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             sdata_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over shift; zeros shift in, so the register drains to 0 by frame end.
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sdata_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/frame_xmtr.sv
// rtl/frame_xmtr.sv - serial frame transmitter (header + body, optional parity via XMTR_PARITY_EN)
`timescale 1ns/1ps

module frame_xmtr
    import frame_pkg::*;
#(
    parameter int                     HEADER_SIZE  = DEFAULT_HEADER_SIZE,
    parameter logic [HEADER_SIZE-1:0] HEADER_VALUE = DEFAULT_HEADER_VALUE,
    parameter int                     BODY_SIZE    = DEFAULT_BODY_SIZE
) (
    input  logic       sclk_i,
    input  logic       rst_i,
    input  logic [7:0] din_i,
    input  logic       valid_i,
    output logic       ack_o,
    output logic       sdata_o,
    output logic       frame_o
);

`ifdef XMTR_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int NBYTES = BODY_SIZE / 8;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int CW     = $clog2(max2(HEADER_SIZE, BODY_SIZE) + 1);
    localparam int FW     = HEADER_SIZE + BODY_SIZE + PAR_BITS;

    localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);
    localparam logic [CW-1:0]  HDR_LAST  = CW'(HEADER_SIZE - 1);
    // With parity the body phase carries one extra bit before returning to COLLECT.
    localparam logic [CW-1:0]  BODY_LAST = CW'(BODY_SIZE - 1 + PAR_BITS);

    frame_state_e         state_q, state_d;
    logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [BODY_SIZE-1:0] buf_q, buf_d;
    logic                 ack_q, ack_d;
    logic                 frame_q, frame_d;
    logic                 load;
    logic                 shift;
    logic [FW-1:0]        load_data;

    // Header and the freshly completed body (plus parity) go to the shifter together.
`ifdef XMTR_PARITY_EN
    assign load_data = {HEADER_VALUE, buf_d, ^buf_d};
`else
    assign load_data = {HEADER_VALUE, buf_d};
`endif

    // Next-state logic: byte collection, header/body bit counting, ACK and FRAME.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        buf_d      = buf_q;
        ack_d      = 1'b0;
        frame_d    = frame_q;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_q)
            COLLECT: begin
                if (valid_i) begin
                    buf_d = BODY_SIZE'({buf_q, din_i});
                    ack_d = 1'b1;
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = '0;
                        bit_cnt_d  = '0;
                        load       = 1'b1;
                        frame_d    = 1'b1;
                        state_d    = HDR;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            HDR: begin
                shift = 1'b1;
                if (bit_cnt_q == HDR_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = BODY;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            BODY: begin
                shift = 1'b1;
                if (bit_cnt_q == BODY_LAST) begin
                    bit_cnt_d = '0;
                    frame_d   = 1'b0;
                    state_d   = COLLECT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = COLLECT;
                byte_cnt_d = '0;
                bit_cnt_d  = '0;
                frame_d    = 1'b0;
            end
        endcase
    end

    // Control registers; reset aborts any frame and discards partial bytes.
    always_ff @(posedge sclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= COLLECT;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            buf_q      <= '0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_q      <= buf_d;
            ack_q      <= ack_d;
            frame_q    <= frame_d;
        end
    end

    frame_piso #(
        .WIDTH (FW)
    ) u_piso (
        .clk_i   (sclk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (load_data),
        .sdata_o (sdata_o)
    );

    assign ack_o   = ack_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_frame_xmtr.sv
// tb/tb_frame_xmtr.sv - self-checking bench for frame_xmtr (honours XMTR_PARITY_EN)
`timescale 1ns/1ps

module tb_frame_xmtr;

`ifdef XMTR_PARITY_EN
    localparam int FLEN = 25;
`else
    localparam int FLEN = 24;
`endif

    logic       sclk = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] din  = 8'h00;
    logic       valid = 1'b0;
    logic       ack_o;
    logic       sdata_o;
    logic       frame_o;

    frame_xmtr dut (
        .sclk_i  (sclk),
        .rst_i   (rst),
        .din_i   (din),
        .valid_i (valid),
        .ack_o   (ack_o),
        .sdata_o (sdata_o),
        .frame_o (frame_o)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          gap;
        logic [23:0] base;
    } vec_t;

    vec_t            vecs [5];
    logic [7:0]      bb [4];
    logic [FLEN-1:0] sb [$];

    int n_checks = 0;
    int n_pass   = 0;

    int              mon_cnt    = 0;
    logic [FLEN-1:0] mon_word   = '0;
    logic            prev_frame = 1'b0;
    int              low_run    = 0;
    int              last_gap   = 0;
    int              ack_bad    = 0;
    int              idle_sdata = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FLEN-1:0] expect_frame(input logic [23:0] base);
`ifdef XMTR_PARITY_EN
        return {base, ^base[15:0]};
`else
        return base;
`endif
    endfunction

    // Monitor: assemble frames from SDATA while FRAME is high, compare against scoreboard.
    always @(negedge sclk) begin
        if (rst) begin
            mon_cnt    = 0;
            mon_word   = '0;
            prev_frame = 1'b0;
        end else begin
            if (frame_o) begin
                mon_word = {mon_word[FLEN-2:0], sdata_o};
                mon_cnt++;
                if (ack_o && prev_frame) ack_bad++;
                if (!prev_frame) last_gap = low_run;
            end else begin
                if (sdata_o) idle_sdata++;
                if (prev_frame) begin
                    check("frame_len", mon_cnt, FLEN);
                    if (sb.size() == 0) begin
                        check("frame_unexpected", 1, 0);
                    end else begin
                        check("frame_data", 32'(mon_word), 32'(sb.pop_front()));
                    end
                    mon_cnt = 0;
                    low_run = 1;
                end else begin
                    low_run++;
                end
            end
            prev_frame = frame_o;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge sclk);
        check("drain_timeout", sb.size(), 0);
        @(posedge sclk); #1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input int gap, input logic [23:0] base);
        logic seen;
        din = b0; valid = 1'b1;
        @(posedge sclk); #1;
        check("ack_byte0", ack_o, 1);
        valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge sclk); #1;
            seen = seen | frame_o | ack_o | sdata_o;
        end
        if (gap > 0) check("gap_idle", seen, 0);
        sb.push_back(expect_frame(base));
        din = b1; valid = 1'b1;
        @(posedge sclk); #1;
        check("ack_byte1", ack_o, 1);
        check("frame_rise", frame_o, 1);
        check("hdr_msb_same_edge", sdata_o, base[23]);
        valid = 1'b0;
        @(posedge sclk); #1;
        check("ack_single_pulse", ack_o, 0);
        wait_drain();
    endtask

    initial begin
        int   idx;
        logic seen;

        vecs[0] = '{8'h35, 8'h24, 0,  24'hA53524};
        vecs[1] = '{8'h00, 8'h00, 0,  24'hA50000};
        vecs[2] = '{8'hFF, 8'hFF, 0,  24'hA5FFFF};
        vecs[3] = '{8'h80, 8'h01, 0,  24'hA58001};
        vecs[4] = '{8'h12, 8'h34, 10, 24'hA51234};
        bb[0] = 8'h5E; bb[1] = 8'h81; bb[2] = 8'hD6; bb[3] = 8'h09;

        // Reset held two cycles, then idle with VALID low.
        rst = 1'b1;
        @(posedge sclk); #1;
        check("rst_sdata", sdata_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_ack", ack_o, 0);
        @(posedge sclk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sclk); #1;
            seen = seen | sdata_o | frame_o | ack_o;
        end
        check("idle_after_reset", seen, 0);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].b0, vecs[v].b1, vecs[v].gap, vecs[v].base);
        end

        // VALID held high: two back-to-back frames, 2-cycle COLLECT gap.
        sb.push_back(expect_frame(24'hA55E81));
        sb.push_back(expect_frame(24'hA5D609));
        ack_bad = 0;
        idx = 0;
        din = bb[0]; valid = 1'b1;
        for (int c = 0; c < 100 && idx < 4; c++) begin
            @(posedge sclk); #1;
            if (ack_o) begin
                idx++;
                if (idx < 4) din = bb[idx];
                else valid = 1'b0;
            end
        end
        check("b2b_bytes_taken", idx, 4);
        wait_drain();
        check("b2b_gap_cycles", last_gap, 2);
        check("no_ack_in_frame", ack_bad, 0);

        // Reset during the 5th body bit of frame A5AABB.
        din = 8'hAA; valid = 1'b1;
        @(posedge sclk); #1;
        din = 8'hBB;
        @(posedge sclk); #1;
        valid = 1'b0;
        repeat (12) @(posedge sclk);
        #1;
        check("pre_abort_frame", frame_o, 1);
        check("pre_abort_sdata", sdata_o, 1);
        rst = 1'b1;
        #1;
        check("abort_sdata", sdata_o, 0);
        check("abort_frame", frame_o, 0);
        @(posedge sclk); #1;
        rst = 1'b0;

        // Partial byte discarded by reset.
        din = 8'h11; valid = 1'b1;
        @(posedge sclk); #1;
        valid = 1'b0;
        rst = 1'b1;
        @(posedge sclk); #1;
        rst = 1'b0;
        @(posedge sclk); #1;
        send_frame(8'h56, 8'h63, 0, 24'hA55663);

        check("sdata_low_outside_frame", idle_sdata, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
